// File: rtl/pl_rv32_mem_arbiter_if.sv
// Request/response bundle between the IF/MEM requesters, the arbiter and the
// single-ported memory.
interface pl_rv32_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              m_req;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [31:0]       m_rdata;

    // Arbiter's view: serves both requesters and drives the memory port.
    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_we, d_be, d_addr, d_wdata,
        input  m_ready, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata
    );

    // Environment's view: requesters plus memory.
    modport master (
        output i_req, i_addr, i_flush, d_req, d_we, d_be, d_addr, d_wdata,
        output m_ready, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/pl_rv32_mem_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D),
// one transaction at a time, D-priority with a bounded streak for I.
module pl_rv32_mem_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    pl_rv32_mem_arbiter_if.slave     bus,
    output logic                     busy
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state, state_next;
    logic                owner_d;
    logic                drop;
    logic [STREAK_W-1:0] d_streak;
    logic                i_pend;
    logic                grant_i, grant_d;
    logic                drop_now;
    logic [ADDR_W-1:0]   addr_sel;

    assign i_pend   = bus.i_req & ~bus.i_flush;
    assign drop_now = drop | bus.i_flush;
    assign addr_sel = grant_d ? bus.d_addr : bus.i_addr;
    assign bus.i_gnt = grant_i;
    assign bus.d_gnt = grant_d;
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        bus.m_req  = (state == ISSUE);
        case (state)
            IDLE: begin
                // Grants are combinational; keep them quiet while reset is held.
                if (!rst) begin
                    if (bus.d_req && (!i_pend || d_streak != STREAK_W'(MAX_D_STREAK)))
                        grant_d = 1'b1;
                    else if (i_pend)
                        grant_i = 1'b1;
                    if (grant_d || grant_i)
                        state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_ready)
                    state_next = bus.m_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (bus.m_rvalid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_d      <= 1'b0;
            drop         <= 1'b0;
            d_streak     <= '0;
            bus.m_we     <= 1'b0;
            bus.m_be     <= '0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            bus.d_rvalid <= 1'b0;
            bus.d_rdata  <= '0;
        end else begin
            bus.i_rvalid <= 1'b0;
            bus.d_rvalid <= 1'b0;

            if (grant_i || grant_d) begin
                owner_d     <= grant_d;
                bus.m_addr  <= addr_sel;
                bus.m_we    <= grant_d & bus.d_we;
                bus.m_be    <= grant_d ? bus.d_be : 4'hF;
                bus.m_wdata <= grant_d ? bus.d_wdata : 32'h0;
            end

            // Streak only grows while I is actually being passed over.
            if (grant_d) begin
                if (!i_pend)
                    d_streak <= '0;
                else if (d_streak != STREAK_W'(MAX_D_STREAK))
                    d_streak <= d_streak + 1'b1;
            end else if (grant_i) begin
                d_streak <= '0;
            end

            if (state == ISSUE && bus.m_ready && bus.m_we) begin
                bus.d_rvalid <= 1'b1;
                bus.d_rdata  <= 32'h0;
            end

            if (state == WAIT && bus.m_rvalid) begin
                if (owner_d) begin
                    bus.d_rvalid <= 1'b1;
                    bus.d_rdata  <= bus.m_rdata;
                end else if (!drop_now) begin
                    bus.i_rvalid <= 1'b1;
                    bus.i_rdata  <= bus.m_rdata;
                end
            end

            // A flush squashes the fetch response but never the bus transaction.
            if (state != IDLE && state_next == IDLE)
                drop <= 1'b0;
            else if (state != IDLE && !owner_d && bus.i_flush)
                drop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pl_rv32_mem_arbiter.sv
// Scoreboard bench for pl_rv32_mem_arbiter: directed scenarios followed by
// randomized traffic against a word-level memory reference model.
module tb_pl_rv32_mem_arbiter;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    pl_rv32_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    pl_rv32_mem_arbiter #(.MAX_D_STREAK(4), .ADDR_W(ADDR_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int errors = 0;
    int checks = 0;

    // Memory responder knobs
    int rdy_wait = 0;
    int rdy_pct  = 100;
    int rv_dmin  = 1;
    int rv_dmax  = 1;
    bit spur     = 1'b0;
    bit rv_real  = 1'b0;

    logic [31:0] mem     [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] ixq[$];
    logic [31:0] dxq[$];
    req_t        issq[$];
    bit          grant_log[$];
    bit          i_inflight = 1'b0;
    bit          i_drop = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a[31:2]) ? mem[a[31:2]] : init_word({a[31:2], 2'b00});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((busy || ixq.size() != 0 || dxq.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        check(name, 32'(n < 300), 32'd1);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a[31:2]]     = v;
        ref_mem[a[31:2]] = v;
    endtask

    // Memory model: random ready, read data some cycles after acceptance.
    initial begin
        bit          acc, a_we, rst_seen;
        logic [3:0]  a_be;
        logic [31:0] a_addr, a_wd, rd_addr;
        int          rv_cnt, req_cycles;
        rv_cnt = 0;
        req_cycles = 0;
        rd_addr = 0;
        bus.m_ready = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata = 32'h0;
        forever begin
            @(negedge clk);
            rst_seen = rst;
            acc    = bus.m_req & bus.m_ready;
            a_we   = bus.m_we;
            a_be   = bus.m_be;
            a_addr = bus.m_addr;
            a_wd   = bus.m_wdata;
            tick();
            rv_real = 1'b0;
            bus.m_rvalid = 1'b0;
            if (rst_seen || rst) begin
                rv_cnt = 0;
                req_cycles = 0;
                bus.m_ready = 1'b0;
            end else begin
                if (acc) begin
                    if (a_we) mem[a_addr[31:2]] = merge(mem_rd(a_addr), a_wd, a_be);
                    else begin
                        rv_cnt  = int'($urandom_range(rv_dmax, rv_dmin));
                        rd_addr = a_addr;
                    end
                end
                if (rv_cnt == 1) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = mem_rd(rd_addr);
                    rv_real      = 1'b1;
                end else if (spur && rv_cnt == 0 && $urandom_range(7, 0) == 0) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = $urandom;
                end
                if (rv_cnt > 0) rv_cnt--;
                req_cycles = bus.m_req ? req_cycles + 1 : 0;
                bus.m_ready = (req_cycles > rdy_wait) && (int'($urandom_range(99, 0)) < rdy_pct);
            end
        end
    end

    // Reference model: expected responses pushed in grant order.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                ixq.delete();
                dxq.delete();
                issq.delete();
                i_inflight = 1'b0;
                i_drop = 1'b0;
            end else begin
                if (i_inflight) begin
                    if (bus.i_flush) i_drop = 1'b1;
                    if (rv_real) begin
                        if (i_drop && ixq.size() != 0) ixq.delete(ixq.size() - 1);
                        i_inflight = 1'b0;
                        i_drop = 1'b0;
                    end
                end
                if (bus.i_gnt) begin
                    ixq.push_back(ref_rd(bus.i_addr));
                    r = {1'b0, 4'hF, bus.i_addr, 32'h0};
                    issq.push_back(r);
                    i_inflight = 1'b1;
                    grant_log.push_back(1'b0);
                end
                if (bus.d_gnt) begin
                    r = {bus.d_we, bus.d_be, bus.d_addr, bus.d_wdata};
                    issq.push_back(r);
                    if (bus.d_we) begin
                        ref_mem[bus.d_addr[31:2]] = merge(ref_rd(bus.d_addr), bus.d_wdata, bus.d_be);
                        dxq.push_back(32'h0);
                    end else begin
                        dxq.push_back(ref_rd(bus.d_addr));
                    end
                    grant_log.push_back(1'b1);
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents something.
    initial begin
        bit   hold;
        req_t last, cur, e;
        hold = 1'b0;
        last = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (bus.i_rvalid) begin
                if (ixq.size() == 0) check("i_rvalid unexpected", 32'd1, 32'd0);
                else check("i_rdata", bus.i_rdata, ixq.pop_front());
            end
            if (bus.d_rvalid) begin
                if (dxq.size() == 0) check("d_rvalid unexpected", 32'd1, 32'd0);
                else check("d_rdata", bus.d_rdata, dxq.pop_front());
            end
            cur = {bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata};
            if (hold) begin
                check("m_req held until ready", 32'(bus.m_req), 32'd1);
                check("m fields stable", 32'(cur == last), 32'd1);
            end
            if (bus.m_req && bus.m_ready) begin
                if (issq.size() == 0) check("m_req unexpected", 32'd1, 32'd0);
                else begin
                    e = issq.pop_front();
                    check("m_addr", bus.m_addr, e.addr);
                    check("m_we/m_be", {27'h0, bus.m_we, bus.m_be}, {27'h0, e.we, e.be});
                    check("m_wdata", bus.m_wdata, e.wdata);
                end
            end
            hold = bus.m_req & ~bus.m_ready;
            last = cur;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ig, dg;
        int n, pulses;

        rst = 1'b1;
        bus.i_req = 1'b1; bus.i_addr = 32'h0; bus.i_flush = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;

        // Reset state, with both requests raised to confirm grants stay low
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset i_gnt", 32'(bus.i_gnt), 32'd0);
        check("reset d_gnt", 32'(bus.d_gnt), 32'd0);
        check("reset m_req", 32'(bus.m_req), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rvalids", {30'h0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        check("reset m_addr", bus.m_addr, 32'h0);
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        rst = 1'b0;
        tick();

        // Single fetch, minimum latency
        preload(32'h100, 32'h00500093);
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        @(negedge clk); check("fetch i_gnt c0", 32'(bus.i_gnt), 32'd1);
        tick(); bus.i_req = 1'b0;
        @(negedge clk);
        check("fetch m_req c1", 32'(bus.m_req), 32'd1);
        check("fetch m_addr c1", bus.m_addr, 32'h100);
        check("fetch m_we/be c1", {27'h0, bus.m_we, bus.m_be}, 32'h0F);
        tick(); @(negedge clk);
        check("fetch wait m_req c2", 32'(bus.m_req), 32'd0);
        check("fetch i_rvalid c2", 32'(bus.i_rvalid), 32'd0);
        tick(); @(negedge clk);
        check("fetch i_rvalid c3", 32'(bus.i_rvalid), 32'd1);
        check("fetch i_rdata c3", bus.i_rdata, 32'h00500093);

        // Store with m_ready held low for two cycles
        tick(); rdy_wait = 2;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
        @(negedge clk); check("store d_gnt", 32'(bus.d_gnt), 32'd1);
        tick(); bus.d_req = 1'b0; bus.d_we = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("store m_req held", 32'(bus.m_req), 32'd1);
            check("store m_addr", bus.m_addr, 32'h2000);
            check("store m_we/be", {27'h0, bus.m_we, bus.m_be}, 32'h13);
            check("store m_wdata", bus.m_wdata, 32'hDEADBEEF);
            tick();
        end
        @(negedge clk);
        check("store d_rvalid", 32'(bus.d_rvalid), 32'd1);
        check("store d_rdata", bus.d_rdata, 32'h0);
        check("store no WAIT busy", 32'(busy), 32'd0);
        tick(); @(negedge clk);
        check("store d_rvalid one pulse", 32'(bus.d_rvalid), 32'd0);
        rdy_wait = 0;

        // Contention: both held, expect D,D,D,D,I repeating
        tick();
        grant_log.delete();
        bus.i_req = 1'b1; bus.i_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h2000;
        n = 0;
        while (grant_log.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("contention grant count", grant_log.size(), 32'd10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            check($sformatf("contention grant %0d is D", k), 32'(grant_log[k]), 32'((k % 5) != 4));
        drain("contention drain");

        // Flush while the fetch waits for data
        rv_dmin = 3; rv_dmax = 3;
        preload(32'h180, 32'h12345678);
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'h180;
        @(negedge clk); check("flush fetch i_gnt", 32'(bus.i_gnt), 32'd1);
        tick(); bus.i_req = 1'b0;
        tick(); bus.i_flush = 1'b1;
        @(negedge clk); check("flush in WAIT", {30'h0, busy, bus.m_req}, 32'h2);
        tick(); bus.i_flush = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.i_rvalid) pulses++;
            tick();
        end
        check("flushed fetch no i_rvalid", pulses, 32'd0);
        rv_dmin = 1; rv_dmax = 1;
        bus.i_req = 1'b1; bus.i_addr = 32'h200;
        n = 0;
        ig = 1'b0;
        while (!ig && n < 20) begin
            @(negedge clk); ig = bus.i_gnt;
            tick(); n++;
        end
        bus.i_req = 1'b0;
        check("refetch granted", 32'(ig), 32'd1);
        n = 0;
        ig = 1'b0;
        while (!ig && n < 20) begin
            @(negedge clk); ig = bus.i_rvalid;
            if (ig) check("refetch i_rdata", bus.i_rdata, init_word(32'h200));
            tick(); n++;
        end
        check("refetch i_rvalid", 32'(ig), 32'd1);

        // Flush at arbitration suppresses the request
        bus.i_req = 1'b1; bus.i_flush = 1'b1; bus.i_addr = 32'h204;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("flush arb i_gnt", 32'(bus.i_gnt), 32'd0);
            check("flush arb m_req", 32'(bus.m_req), 32'd0);
            tick();
        end
        bus.i_req = 1'b0; bus.i_flush = 1'b0;

        // Reset in the middle of ISSUE
        rdy_wait = 5;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400; bus.d_be = 4'hF;
        @(negedge clk); check("rst-test d_gnt", 32'(bus.d_gnt), 32'd1);
        tick(); bus.d_req = 1'b0;
        @(negedge clk); check("rst-test ISSUE m_req", 32'(bus.m_req), 32'd1);
        tick();
        rst = 1'b1; bus.d_req = 1'b1; bus.i_req = 1'b1;
        #1;
        check("mid rst m_req", 32'(bus.m_req), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst gnts", {30'h0, bus.i_gnt, bus.d_gnt}, 32'd0);
        check("mid rst rvalids", {30'h0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
        bus.i_req = 1'b0;
        tick(); tick();
        rdy_wait = 0;
        rst = 1'b0;
        @(negedge clk); check("post rst d_gnt", 32'(bus.d_gnt), 32'd1);
        tick(); bus.d_req = 1'b0;
        drain("post rst drain");

        // Randomized traffic
        rdy_pct = 60; rv_dmin = 1; rv_dmax = 3; spur = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ig = bus.i_gnt;
            dg = bus.d_gnt;
            tick();
            if (ig) bus.i_req = 1'b0;
            if (dg) bus.d_req = 1'b0;
            if (!bus.i_req && $urandom_range(2, 0) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 32'h1000 | ($urandom_range(15, 0) << 2);
            end
            bus.i_flush = ($urandom_range(9, 0) == 0);
            if (!bus.d_req && $urandom_range(1, 0) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(1, 0));
                bus.d_be    = 4'($urandom_range(15, 1));
                bus.d_addr  = 32'h1000 | ($urandom_range(15, 0) << 2);
                bus.d_wdata = $urandom;
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.i_flush = 1'b0;
        spur = 1'b0;
        drain("random drain");
        tick(); tick();
        check("final i queue empty", ixq.size(), 32'd0);
        check("final d queue empty", dxq.size(), 32'd0);
        check("final issue queue empty", issq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pl_rv32_mem_arbiter.md
Name: pl_rv32_mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (I, read-only) and the load/store requester (D, read/write with byte enables).
- Sits between the IF/MEM stages of the pipelined RV32 core and the single-ported memory.
- Issues one transaction at a time and routes each response back to its owner.
- D has priority, bounded by an anti-starvation limit for I; supports squashing an in-flight fetch on pipeline flush.

Parameters:
- MAX_D_STREAK, 4, number of consecutive D grants allowed while i_req is pending before I is forced to win (>=1).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  squash pending/in-flight fetch
- i_gnt  out  1  fetch accepted (1-cycle pulse)
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  32  fetch data
- d_req  in  1  load/store request, held until d_gnt
- d_we  in  1  1 = store
- d_be  in  4  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
- d_rdata  out  32  load data (0 for stores)
- m_req  out  1  memory request
- m_we, m_be, m_addr, m_wdata  out  1/4/ADDR_W/32  registered request fields
- m_ready  in  1  memory accepts request when m_req & m_ready
- m_rvalid  in  1  read data valid, earliest the cycle after acceptance
- m_rdata  in  32  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=I, drop=0, d_streak=0.
  - All outputs 0; m_req drops immediately.
  - An in-flight memory transaction is abandoned.
- States: IDLE, ISSUE, WAIT.
- IDLE arbitration (combinational grant in the same cycle):
  - i_req is ignored if i_flush=1 that cycle.
  - Only one valid request: grant it.
  - Both valid: grant D unless d_streak==MAX_D_STREAK, in which case grant I.
- On grant:
  - Pulse the requester's gnt.
  - Capture addr/we/be/wdata into m_* registers; I forces we=0, be=4'hF, wdata=0.
  - Record owner; go to ISSUE.
- d_streak update:
  - D grant with i_req&!i_flush high: increment (saturating).
  - D grant with I not pending: clear.
  - I grant: clear.
- ISSUE:
  - m_req=1; fields stable until m_ready sampled high.
  - Accepted write: go to IDLE; d_rvalid=1 next cycle, d_rdata=0.
  - Accepted read: go to WAIT.
- WAIT:
  - m_req=0.
  - On m_rvalid: register m_rdata into the owner's rdata and pulse the owner's rvalid next cycle; go to IDLE.
  - m_rvalid is ignored in IDLE/ISSUE.
- Back-to-back: a new grant may occur in the IDLE cycle in which the previous rvalid pulse is asserted.
- Minimum read latency: gnt at cycle 0, m_req at 1 (m_ready=1), m_rvalid at 2, rvalid at 3.
- Flush:
  - i_flush=1 while owner=I and state is ISSUE or WAIT sets drop=1.
  - The memory transaction still completes; m_req is never withdrawn before m_ready.
  - i_rvalid is suppressed for that response; drop clears on entering IDLE.
  - i_flush has no effect on D transactions.
- rdata holds its last value between pulses.
- Protocol assumption: requesters hold req/fields stable until gnt. A req deasserted before gnt is simply not granted.

Test Plan:
- Single fetch: i_req, i_addr=0x100; memory m_ready=1, m_rvalid at +1 with 0x00500093 -> i_gnt at cycle 0, m_addr=0x100, m_we=0, m_be=F at cycle 1, i_rvalid with i_rdata=0x00500093 at cycle 3.
- Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x2000, d_wdata=0xDEADBEEF; m_ready low for 2 cycles -> m_req held 3 cycles with stable fields, d_rvalid pulse 1 cycle after acceptance, d_rdata=0, no WAIT state.
- Contention: i_req and d_req both held continuously, MAX_D_STREAK=4, 1-cycle-wait memory -> grant order D,D,D,D,I,D,D,D,D,I; d_streak clears after each I grant.
- Flush in flight: fetch granted, i_flush pulses in WAIT, m_rvalid returns 0x12345678 -> no i_rvalid pulse; next fetch for 0x200 is granted and returns normally.
- Flush at arbitration: i_req with i_flush=1 in IDLE and d_req=0 -> no i_gnt, m_req stays 0.
- Reset mid-transaction: rst asserted in ISSUE with m_req=1 -> m_req, gnt and rvalid outputs 0 immediately, busy=0; after release a fresh d_req is granted in 1 cycle.
